core_ctrl: RTL



---
 rtl/core_ctrl_pkg.sv | 15 +
 rtl/core_ctrl_if.sv | 33 +++
 rtl/core_ctrl_dly.sv | 51 +++++
 rtl/core_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and limits for the per-core tile sequencer.
package core_ctrl_pkg;

    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned WAIT_W      = $clog2(MEM_LAT_MAX);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_COMP = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/core_ctrl_if.sv
// Launch/config handshake plus core memory, LBUF and ABUF port signals of core_ctrl.
interface core_ctrl_if #(
    parameter int unsigned GBUS_ADDR = 12,
    parameter int unsigned LBUF_ADDR = 4,
    parameter int unsigned CDATA_BIT = 8
);
    logic                 start;
    logic [GBUS_ADDR-1:0] cfg_base_addr;
    logic [CDATA_BIT-1:0] cfg_acc_num;
    logic [CDATA_BIT-1:0] cfg_tile_num;
    logic                 busy;
    logic                 done;
    logic [GBUS_ADDR-1:0] cmem_raddr;
    logic                 cmem_ren;
    logic [LBUF_ADDR-1:0] lbuf_waddr;
    logic [LBUF_ADDR-1:0] lbuf_raddr;
    logic                 lbuf_ren;
    logic [LBUF_ADDR-1:0] abuf_raddr;
    logic                 abuf_ren;

    // master launches tiles and observes the buffer ports; slave is the sequencer
    modport master (
        output start, cfg_base_addr, cfg_acc_num, cfg_tile_num,
        input  busy, done, cmem_raddr, cmem_ren, lbuf_waddr,
               lbuf_raddr, lbuf_ren, abuf_raddr, abuf_ren
    );

    modport slave (
        input  start, cfg_base_addr, cfg_acc_num, cfg_tile_num,
        output busy, done, cmem_raddr, cmem_ren, lbuf_waddr,
               lbuf_raddr, lbuf_ren, abuf_raddr, abuf_ren
    );
endinterface

// File: rtl/core_ctrl_dly.sv
// Delays the LOAD row index by DEPTH cycles to form the LBUF write address;
// the output holds its last valid index between bursts.
module core_ctrl_dly #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_idx,
    output logic [WIDTH-1:0] out_idx
);

    logic             tail_vld;
    logic [WIDTH-1:0] tail_idx;

    if (DEPTH <= 1) begin : g_direct
        assign tail_vld = in_vld;
        assign tail_idx = in_idx;
    end else begin : g_pipe
        logic [DEPTH-2:0] vld_q;
        logic [WIDTH-1:0] idx_q [DEPTH-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                idx_q <= '{default: '0};
            end else begin
                vld_q[0] <= in_vld;
                idx_q[0] <= in_idx;
                for (int i = 1; i < int'(DEPTH) - 1; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    idx_q[i] <= idx_q[i-1];
                end
            end
        end

        assign tail_vld = vld_q[DEPTH-2];
        assign tail_idx = idx_q[DEPTH-2];
    end

    // final stage only loads on a real write so the address holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx <= '0;
        end else if (tail_vld) begin
            out_idx <= tail_idx;
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// Per-core sequencer: stages each weight tile from core memory into LBUF, then
// streams LBUF and ABUF rows into the MAC; one accumulated output per tile.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned GBUS_ADDR  = 12,
    parameter int unsigned LBUF_DEPTH = 16,
    parameter int unsigned LBUF_ADDR  = $clog2(LBUF_DEPTH),
    parameter int unsigned CDATA_BIT  = 8,
    parameter int unsigned MEM_LAT    = 1
) (
    input logic        clk,
    input logic        rst,
    core_ctrl_if.slave bus
);

    localparam int unsigned N_W = LBUF_ADDR + 1;

    state_e               state, state_nxt;
    logic [LBUF_ADDR-1:0] row, row_nxt;
    logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
    logic [CDATA_BIT-1:0] tiles_left, tiles_nxt;
    logic [GBUS_ADDR-1:0] tile_base, base_nxt;
    logic [N_W-1:0]       n_rows, n_nxt;

    logic [N_W-1:0]       n_cfg;
    logic                 row_last;

    logic                 busy_d, done_d, cmem_ren_d, comp_d;
    logic [GBUS_ADDR-1:0] cmem_raddr_d;
    logic [LBUF_ADDR-1:0] raddr_d;

    logic                 busy_q, done_q, cmem_ren_q, comp_q;
    logic [GBUS_ADDR-1:0] cmem_raddr_q;
    logic [LBUF_ADDR-1:0] raddr_q;
    logic [LBUF_ADDR-1:0] waddr_q;

    // row count clamped to the buffer depth
    assign n_cfg = (32'(bus.cfg_acc_num) > 32'(LBUF_DEPTH)) ? N_W'(LBUF_DEPTH)
                                                            : N_W'(bus.cfg_acc_num);
    assign row_last = (N_W'(row) == (n_rows - N_W'(1)));

    // state register and sequencing counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row        <= '0;
            wait_cnt   <= '0;
            tiles_left <= '0;
            tile_base  <= '0;
            n_rows     <= '0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            wait_cnt   <= wait_nxt;
            tiles_left <= tiles_nxt;
            tile_base  <= base_nxt;
            n_rows     <= n_nxt;
        end
    end

    // next-state and counter update
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        wait_nxt  = wait_cnt;
        tiles_nxt = tiles_left;
        base_nxt  = tile_base;
        n_nxt     = n_rows;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    n_nxt     = n_cfg;
                    tiles_nxt = bus.cfg_tile_num;
                    base_nxt  = bus.cfg_base_addr;
                    row_nxt   = '0;
                    if (n_cfg == '0 || bus.cfg_tile_num == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (row_last) begin
                    state_nxt = S_WAIT;
                    wait_nxt  = '0;
                end else begin
                    row_nxt = row + LBUF_ADDR'(1);
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_W'(MEM_LAT - 1)) begin
                    state_nxt = S_COMP;
                    row_nxt   = '0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_COMP: begin
                if (row_last) begin
                    if (tiles_left > CDATA_BIT'(1)) begin
                        tiles_nxt = tiles_left - CDATA_BIT'(1);
                        base_nxt  = tile_base + GBUS_ADDR'(n_rows);
                        row_nxt   = '0;
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    row_nxt = row + LBUF_ADDR'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // output decode from the upcoming state so registered outputs line up with it
    always_comb begin
        busy_d       = (state_nxt != S_IDLE);
        done_d       = (state_nxt == S_DONE);
        cmem_ren_d   = (state_nxt == S_LOAD);
        comp_d       = (state_nxt == S_COMP);
        cmem_raddr_d = '0;
        raddr_d      = '0;
        if (cmem_ren_d) begin
            cmem_raddr_d = base_nxt + GBUS_ADDR'(row_nxt);
        end
        if (comp_d) begin
            raddr_d = row_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cmem_ren_q   <= 1'b0;
            cmem_raddr_q <= '0;
            comp_q       <= 1'b0;
            raddr_q      <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            cmem_ren_q   <= cmem_ren_d;
            cmem_raddr_q <= cmem_raddr_d;
            comp_q       <= comp_d;
            raddr_q      <= raddr_d;
        end
    end

    // the row issued this cycle lands in LBUF MEM_LAT cycles later
    core_ctrl_dly #(
        .WIDTH (LBUF_ADDR),
        .DEPTH (MEM_LAT)
    ) u_dly (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (cmem_ren_q),
        .in_idx  (row),
        .out_idx (waddr_q)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cmem_ren   = cmem_ren_q;
    assign bus.cmem_raddr = cmem_raddr_q;
    assign bus.lbuf_ren   = comp_q;
    assign bus.lbuf_raddr = raddr_q;
    assign bus.abuf_ren   = comp_q;
    assign bus.abuf_raddr = raddr_q;
    assign bus.lbuf_waddr = waddr_q;

endmodule
